// File: rtl/stk_cmd_arb.sv
// Command arbiter in front of stk_pipe: per-engine credit-limited round-robin
// selection into a single output register with valid/ready handshake.

package cfg_pkg;
    localparam int ENGS_N = 4;
endpackage

package stk_pkg;
    typedef logic [2:0] opcode_t;
    localparam opcode_t OP_NOP  = 3'd0;
    localparam opcode_t OP_PUSH = 3'd1;
    localparam opcode_t OP_POP  = 3'd2;
    localparam opcode_t OP_PEEK = 3'd3;
endpackage

module stk_cmd_arb #(
    parameter int ENGS_N  = cfg_pkg::ENGS_N,
    parameter int CREDITS = 2,
    parameter int DAT_W   = 128,
    localparam int ENG_W  = (ENGS_N > 1) ? $clog2(ENGS_N) : 1,
    localparam int CNT_W  = $clog2(CREDITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  stk_pkg::opcode_t     i_cmd_opcode [ENGS_N],
    input  logic [DAT_W-1:0]     i_cmd_dat    [ENGS_N],
    output logic [ENGS_N-1:0]    o_cmd_ack,
    output logic                 o_pipe_vld,
    input  logic                 i_pipe_rdy,
    output logic [ENG_W-1:0]     o_pipe_eng,
    output stk_pkg::opcode_t     o_pipe_opcode,
    output logic [DAT_W-1:0]     o_pipe_dat,
    input  logic [ENGS_N-1:0]    i_rsp_vld
);

    logic                 vld_q;
    logic [ENG_W-1:0]     ptr_q;
    logic [ENG_W-1:0]     ptr_d;
    logic [CNT_W-1:0]     cnt_q [ENGS_N];
    logic [CNT_W-1:0]     cnt_d [ENGS_N];
    logic [ENG_W-1:0]     eng_q;
    stk_pkg::opcode_t     opc_q;
    logic [DAT_W-1:0]     dat_q;

    logic [ENGS_N-1:0]    elig;
    logic                 found;
    logic [ENG_W-1:0]     gnt_idx;
    logic                 free;
    logic                 cap;
    int                   idx;

    // Eligibility: a real request and a spare credit for that engine.
    always_comb begin
        elig = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            elig[e] = (i_cmd_opcode[e] != stk_pkg::OP_NOP) && (int'(cnt_q[e]) < CREDITS);
        end
    end

    // Round-robin search starting at ptr, first eligible engine wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < ENGS_N; k++) begin
            idx = (int'(ptr_q) + k) % ENGS_N;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_idx = ENG_W'(idx);
            end
        end
    end

    // Capture happens only when the output register can take a new command;
    // the ack is suppressed during reset so no engine believes it was served.
    always_comb begin
        free      = !vld_q || i_pipe_rdy;
        cap       = free && found && !rst;
        o_cmd_ack = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            o_cmd_ack[e] = cap && (gnt_idx == ENG_W'(e));
        end
    end

    // Next pointer and credit counters; capture and return together cancel out.
    always_comb begin
        ptr_d = ptr_q;
        if (cap) begin
            ptr_d = (gnt_idx == ENG_W'(ENGS_N - 1)) ? '0 : gnt_idx + ENG_W'(1);
        end
        for (int e = 0; e < ENGS_N; e++) begin
            cnt_d[e] = cnt_q[e];
            if (o_cmd_ack[e] && !i_rsp_vld[e]) begin
                cnt_d[e] = cnt_q[e] + CNT_W'(1);
            end else if (!o_cmd_ack[e] && i_rsp_vld[e] && (cnt_q[e] != '0)) begin
                cnt_d[e] = cnt_q[e] - CNT_W'(1);
            end
        end
    end

    // Control state: valid flag, arbitration pointer and credit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            ptr_q <= '0;
            for (int e = 0; e < ENGS_N; e++) begin
                cnt_q[e] <= '0;
            end
        end else begin
            if (free) begin
                vld_q <= found;
            end
            ptr_q <= ptr_d;
            for (int e = 0; e < ENGS_N; e++) begin
                cnt_q[e] <= cnt_d[e];
            end
        end
    end

    // Payload register: loaded on capture only, meaningless while vld_q is low.
    always_ff @(posedge clk) begin
        if (cap) begin
            eng_q <= gnt_idx;
            opc_q <= i_cmd_opcode[gnt_idx];
            dat_q <= i_cmd_dat[gnt_idx];
        end
    end

    // A response for an engine with nothing outstanding is a protocol error upstream.
    always_ff @(posedge clk) begin
        for (int e = 0; e < ENGS_N; e++) begin
            if (!rst && i_rsp_vld[e] && (cnt_q[e] == '0)) begin
                assert (1'b0) else $warning("stk_cmd_arb: credit return on engine %0d with no command outstanding", e);
            end
        end
    end

    assign o_pipe_vld    = vld_q;
    assign o_pipe_eng    = eng_q;
    assign o_pipe_opcode = opc_q;
    assign o_pipe_dat    = dat_q;

endmodule

// File: tb/tb_stk_cmd_arb.sv
// Bench for stk_cmd_arb: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level reference model.

module tb_stk_cmd_arb;

    localparam int N     = 4;
    localparam int CRED  = 2;
    localparam int DW    = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        opc [N];
    logic [DW-1:0]     dat [N];
    logic [N-1:0]      ack;
    logic              pvld;
    logic              rdy;
    logic [1:0]        peng;
    logic [2:0]        popc;
    logic [DW-1:0]     pdat;
    logic [N-1:0]      rsp;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int            m_cnt [N];
    int            m_ptr;
    bit            m_vld;
    int            m_eng;
    logic [2:0]    m_opc;
    logic [DW-1:0] m_dat;
    logic [N-1:0]  exp_ack;
    logic [N-1:0]  last_ack;

    stk_cmd_arb #(.ENGS_N(N), .CREDITS(CRED), .DAT_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_opcode (opc),
        .i_cmd_dat    (dat),
        .o_cmd_ack    (ack),
        .o_pipe_vld   (pvld),
        .i_pipe_rdy   (rdy),
        .o_pipe_eng   (peng),
        .o_pipe_opcode(popc),
        .o_pipe_dat   (pdat),
        .i_rsp_vld    (rsp)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rnd_dat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven (just after a falling edge).
    // Predict the ack from the model, compare everything, then advance the model
    // across the rising edge.
    task automatic step(input string tag);
        bit free;
        int g;
        #1;
        exp_ack = '0;
        g = -1;
        free = !m_vld || rdy;
        if (!rst && free) begin
            for (int k = 0; k < N; k++) begin
                int e;
                e = (m_ptr + k) % N;
                if (g < 0 && opc[e] != 3'd0 && m_cnt[e] < CRED) g = e;
            end
            if (g >= 0) exp_ack[g] = 1'b1;
        end
        check({tag, ".ack"}, DW'(ack), DW'(exp_ack));
        check({tag, ".vld"}, DW'(pvld), DW'(m_vld));
        if (m_vld) begin
            check({tag, ".eng"}, DW'(peng), DW'(m_eng));
            check({tag, ".opc"}, DW'(popc), DW'(m_opc));
            check({tag, ".dat"}, pdat, m_dat);
        end
        @(posedge clk);
        if (rst) begin
            m_vld = 1'b0;
            m_ptr = 0;
            for (int e = 0; e < N; e++) m_cnt[e] = 0;
        end else begin
            if (free) begin
                if (g >= 0) begin
                    m_vld = 1'b1;
                    m_eng = g;
                    m_opc = opc[g];
                    m_dat = dat[g];
                    m_ptr = (g + 1) % N;
                end else begin
                    m_vld = 1'b0;
                end
            end
            for (int e = 0; e < N; e++) begin
                m_cnt[e] = m_cnt[e] + int'(exp_ack[e]) - int'(rsp[e]);
                if (m_cnt[e] < 0) m_cnt[e] = 0;
            end
        end
        last_ack = exp_ack;
        @(negedge clk);
        // a served engine presents fresh data for its next command
        for (int e = 0; e < N; e++) if (last_ack[e]) dat[e] = rnd_dat();
    endtask

    task automatic idle_inputs();
        for (int e = 0; e < N; e++) begin
            opc[e] = 3'd0;
            dat[e] = rnd_dat();
        end
        rdy = 1'b1;
        rsp = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    initial begin
        m_vld = 1'b0; m_ptr = 0; m_eng = 0; m_opc = '0; m_dat = '0;
        for (int e = 0; e < N; e++) m_cnt[e] = 0;
        last_ack = '0;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        step("rst0");
        step("rst1");
        check("rst.vld_const", DW'(pvld), DW'(0));
        rst = 1'b0;

        // All engines push, rdy high, credits returned one cycle after capture.
        for (int e = 0; e < N; e++) opc[e] = 3'd1;
        for (int i = 0; i < 10; i++) begin
            rsp = last_ack;
            step("rr");
            check("rr.order", DW'(last_ack), DW'(4'b0001 << (i % 4)));
        end
        rsp = '0;

        // Reset while a command sits in the output register.
        check("midrst.vld_before", DW'(pvld), DW'(1));
        rst = 1'b1;
        step("midrst");
        rst = 1'b0;
        check("midrst.vld_after", DW'(pvld), DW'(0));
        step("midrst.first");
        check("midrst.eng0_wins", DW'(last_ack), DW'(4'b0001));
        do_reset();

        // Engine 2 alone: two credits, then stall until a credit comes back.
        opc[2] = 3'd2;
        for (int i = 0; i < 4; i++) begin
            step("cred");
            check("cred.ack", DW'(last_ack), (i < 2) ? DW'(4'b0100) : DW'(0));
        end
        rsp[2] = 1'b1;
        step("cred.ret");
        check("cred.ret_noack", DW'(last_ack), DW'(0));
        rsp[2] = 1'b0;
        step("cred.resume");
        check("cred.resume_ack", DW'(last_ack), DW'(4'b0100));
        do_reset();

        // Backpressure: engine 0 captured, stall 5 cycles, then engine 1.
        opc[0] = 3'd1; opc[1] = 3'd3;
        rdy = 1'b0;
        step("bp.cap");
        check("bp.first", DW'(last_ack), DW'(4'b0001));
        for (int i = 0; i < 5; i++) begin
            step("bp.hold");
            check("bp.hold_eng", DW'(peng), DW'(0));
            check("bp.hold_noack", DW'(last_ack), DW'(0));
        end
        rdy = 1'b1;
        step("bp.release");
        check("bp.eng1", DW'(last_ack), DW'(4'b0010));
        do_reset();

        // Capture and credit return on the same engine in the same cycle.
        opc[1] = 3'd1;
        step("same.cap1");
        rsp[1] = 1'b1;
        step("same.both");
        rsp[1] = 1'b0;
        step("same.cap2");
        check("same.cap2_ack", DW'(last_ack), DW'(4'b0010));
        step("same.full");
        check("same.full_noack", DW'(last_ack), DW'(0));
        do_reset();

        // Spurious credit return on engine 3: counter must not underflow.
        rsp[3] = 1'b1;
        step("uflow.rsp");
        rsp[3] = 1'b0;
        opc[3] = 3'd1;
        for (int i = 0; i < 4; i++) begin
            step("uflow.req");
            check("uflow.ack", DW'(last_ack), (i < 2) ? DW'(4'b1000) : DW'(0));
        end
        do_reset();

        // Randomized traffic: requests held until acked, legal credit returns.
        for (int i = 0; i < 400; i++) begin
            for (int e = 0; e < N; e++) begin
                if (last_ack[e] || opc[e] == 3'd0) begin
                    opc[e] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
                    dat[e] = rnd_dat();
                end
                rsp[e] = (m_cnt[e] > 0) && ($urandom_range(0, 2) == 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stk_cmd_arb.md
STK_CMD_ARB -- requirements
Module: stk_cmd_arb

Interface
REQ-001 Parameter ENGS_N, default cfg_pkg::ENGS_N (4), number of requesting engines.
REQ-002 Parameter CREDITS, default 2, maximum commands outstanding per engine.
REQ-003 Parameter DAT_W, default 128, command data width.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset; synchronous and active-high.
REQ-006 Port i_cmd_opcode  input  ENGS_N x stk_pkg::opcode_t  per-engine command; stk_pkg::OP_NOP means no request.
REQ-007 Port i_cmd_dat  input  ENGS_N x DAT_W  per-engine command data.
REQ-008 Port o_cmd_ack  output  ENGS_N  one-hot pulse: engine's command captured this cycle.
REQ-009 Port o_pipe_vld  output  1  command valid towards stk_pipe.
REQ-010 Port i_pipe_rdy  input  1  stk_pipe accepts the command.
REQ-011 Port o_pipe_eng  output  $clog2(ENGS_N)  source engine index.
REQ-012 Port o_pipe_opcode  output  stk_pkg::opcode_t  selected opcode.
REQ-013 Port o_pipe_dat  output  DAT_W  selected data.
REQ-014 Port i_rsp_vld  input  ENGS_N  per-engine response from stk_pipe; each asserted bit returns one credit.

Function
REQ-015 Engine e SHALL be eligible when i_cmd_opcode[e] != OP_NOP and credit count cnt[e] < CREDITS.
REQ-016 Block SHALL hold a single output register (o_pipe_vld, eng, opcode, dat); register is free when o_pipe_vld=0 or i_pipe_rdy=1.
REQ-017 When the register is free and at least one engine is eligible, the block SHALL select one engine round-robin, beginning at index ptr and wrapping from ENGS_N-1 to 0, and load its opcode/dat/index on the next edge.
REQ-018 o_cmd_ack[e] SHALL be driven combinationally high in the capture cycle only; at most one bit set per cycle.
REQ-019 Engines hold opcode/dat stable until acked; the block SHALL NOT sample an engine in any other cycle.
REQ-020 After capture of engine g, ptr SHALL become (g+1) mod ENGS_N; ptr SHALL be unchanged in cycles without capture.
REQ-021 Register free, no engine eligible: o_pipe_vld SHALL clear on the next edge if i_pipe_rdy=1, else hold.
REQ-022 o_pipe_vld=1 and i_pipe_rdy=0: register contents SHALL hold unchanged and no ack SHALL issue.
REQ-023 Capture latency: ack in cycle N, o_pipe_vld with that command in cycle N+1; sustained throughput one command/cycle when i_pipe_rdy=1.
REQ-024 cnt[e] ($clog2(CREDITS+1) bits) SHALL increment on capture of e, decrement on i_rsp_vld[e], and hold when both occur in the same cycle.
REQ-025 i_rsp_vld[e] with cnt[e]=0 SHALL leave cnt[e] at 0 (no underflow); simulation assertion fires.
REQ-026 A credit returned in cycle N SHALL make the engine eligible in cycle N+1, not N.

Reset
REQ-027 With rst=1 at an edge: o_pipe_vld=0, ptr=0, all cnt=0; o_cmd_ack SHALL be 0 while rst=1.
REQ-028 Reset mid-operation SHALL discard any registered command without handshake; output/data fields are don't-care while o_pipe_vld=0.

Verification
REQ-029 All 4 engines request PUSH, i_pipe_rdy=1 constant -> acks 0,1,2,3,0,... one per cycle; o_pipe_eng follows one cycle later.
REQ-030 Engine 2 only, CREDITS=2, no responses -> two acks, then no ack; i_rsp_vld[2] pulse -> ack resumes on the following cycle.
REQ-031 Engines 0,1 request, i_pipe_rdy=0 for 5 cycles after first capture -> o_pipe_eng=0 held, no further ack; rdy=1 -> engine 1 acked same cycle.
REQ-032 Capture and i_rsp_vld on same engine same cycle with cnt=1 -> cnt stays 1.
REQ-033 i_rsp_vld[3] with cnt[3]=0 -> cnt[3] remains 0, assertion flagged.
REQ-034 rst asserted while o_pipe_vld=1 -> next cycle o_pipe_vld=0, ptr=0; engine 0 wins first post-reset arbitration.
